// File: rtl/spi_slave.sv
// spi_slave -- SPI slave (modes 0-3, MSB-first, 8-bit frames) in the clk domain.
//
// sck, mosi and cs_n are oversampled through SYNC_STAGES-deep synchronizers;
// every SPI edge is detected on the synchronized copies, so sck must run at
// most clk/8 with high/low times of at least 3 clk periods.
//
// Ports
//   clk        system clock (only clock)
//   reset_n    asynchronous active-low reset
//   cpol_cpha  SPI mode {CPOL, CPHA}, latched when cs_n falls
//   sck        SPI clock from the master (async)
//   mosi       master-out data (async)
//   cs_n       active-low chip select (async)
//   miso       slave-out data, 0 whenever miso_oe is 0
//   miso_oe    tri-state enable for miso, equals busy
//   tx_data    next byte to transmit; accepted on tx_valid && tx_ready
//   tx_valid   tx_data qualifier
//   tx_ready   one-entry tx buffer is empty
//   rx_data    last byte received
//   rx_valid   rx_data holds an unconsumed byte; cleared on rx_valid && rx_ready
//   rx_ready   consumer accepts rx_data
//   busy       a frame is in progress (LOAD or SHIFT)
//   underrun   1-cycle pulse: a byte was clocked out with no tx data (0x00 sent)
//   overrun    1-cycle pulse: a byte completed while rx_valid was still set
//   frame_err  1-cycle pulse: cs_n rose with a partial byte (1..7 bits)
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] cpol_cpha,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       underrun,
  output logic       overrun,
  output logic       frame_err
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // ---- stage 0: input synchronizers and edge detection ----
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  // Fills with ones after reset; cs_n edges are ignored until the whole
  // synchronizer chain (and cs_d) holds real pin samples, so a cs_n already
  // low at reset release never looks like a falling edge.
  logic [SYNC_STAGES:0]   fill;
  logic                   sck_d;
  logic                   cs_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      fill      <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, mosi_s, cs_s, armed;
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign armed  = fill[SYNC_STAGES];

  logic       cs_fall, cs_rise, sck_rise, sck_fall;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic [1:0] mode_r;

  assign cs_fall     = armed &  cs_d & ~cs_s;
  assign cs_rise     = armed & ~cs_d &  cs_s;
  assign sck_rise    =  sck_s & ~sck_d;
  assign sck_fall    = ~sck_s &  sck_d;
  assign lead_edge   = mode_r[1] ? sck_fall : sck_rise;
  assign trail_edge  = mode_r[1] ? sck_rise : sck_fall;
  assign sample_edge = mode_r[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_r[0] ? lead_edge  : trail_edge;

  // ---- stage 1: frame FSM, shift registers, tx/rx buffers ----
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_buf;
  logic              tx_full;
  logic              skip_shift;
  logic              mid_frame;
  logic              ld_from_buf;
  logic              und_pend;

  // LOAD only peeks at the tx buffer; the entry is released (and a missing
  // entry reported as underrun) at the first sample edge of the byte. A LOAD
  // issued right after the last byte of a frame therefore neither eats the
  // next frame's data nor flags an underrun when cs_n rises cleanly.
  //
  // skip_shift swallows one non-sample edge: with CPHA=1 the first leading
  // edge (MSB already on miso); with CPHA=0 in a continuing frame, the
  // trailing edge of the previous byte's last bit, which arrives after LOAD
  // has already presented the new MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mode_r      <= 2'b00;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      skip_shift  <= 1'b0;
      mid_frame   <= 1'b0;
      ld_from_buf <= 1'b0;
      und_pend    <= 1'b0;
    end else begin
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            mode_r    <= cpol_cpha;
            mid_frame <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end

        LOAD: begin
          if (cs_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tx_sr       <= tx_full ? tx_buf : '0;
            ld_from_buf <= tx_full;
            und_pend    <= ~tx_full;
            bit_cnt     <= '0;
            skip_shift  <= mode_r[0] | mid_frame;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt != 3'd0) begin
              frame_err <= 1'b1;
            end
            bit_cnt     <= '0;
            skip_shift  <= 1'b0;
            ld_from_buf <= 1'b0;
            und_pend    <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (sample_edge) begin
            if (bit_cnt == 3'd0) begin
              if (ld_from_buf) begin
                tx_full <= 1'b0;
              end
              underrun    <= und_pend;
              ld_from_buf <= 1'b0;
              und_pend    <= 1'b0;
            end
            rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
            if (bit_cnt == 3'd7) begin
              rx_data   <= {rx_sr[DATA_W-2:0], mosi_s};
              rx_valid  <= 1'b1;
              overrun   <= rx_valid & ~rx_ready;
              bit_cnt   <= '0;
              mid_frame <= 1'b1;
              state     <= LOAD;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else if (shift_edge) begin
            if (skip_shift) begin
              skip_shift <= 1'b0;
            end else begin
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign miso_oe  = busy;
  assign miso     = busy & tx_sr[DATA_W-1];
  assign tx_ready = ~tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- directed and randomized bench for spi_slave.
// A behavioural SPI master drives sck/mosi/cs_n at clk/10; pulse outputs are
// counted and rx handshakes logged by monitors, and each step compares the
// DUT against values derived from the SPI byte-level rules.
module tb_spi_slave;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] cpol_cpha;
  logic       sck, mosi, cs_n;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       busy, underrun, overrun, frame_err;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpol_cpha (cpol_cpha),
    .sck       (sck),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .underrun  (underrun),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Monitors: pulse counters and accepted rx bytes.
  int         und_cnt  = 0;
  int         ovr_cnt  = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_log[$];

  always @(posedge clk) begin
    if (underrun)  und_cnt  <= und_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_valid && rx_ready) rx_log.push_back(rx_data);
  end

  int base_u, base_o, base_f, base_rx;

  task automatic snap();
    base_u  = und_cnt;
    base_o  = ovr_cnt;
    base_f  = ferr_cnt;
    base_rx = rx_log.size();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_miso"},      {31'd0, miso},      32'd0);
    check({p, "_miso_oe"},   {31'd0, miso_oe},   32'd0);
    check({p, "_busy"},      {31'd0, busy},      32'd0);
    check({p, "_rx_valid"},  {31'd0, rx_valid},  32'd0);
    check({p, "_underrun"},  {31'd0, underrun},  32'd0);
    check({p, "_overrun"},   {31'd0, overrun},   32'd0);
    check({p, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({p, "_rx_data"},   {24'd0, rx_data},   32'd0);
    check({p, "_tx_ready"},  {31'd0, tx_ready},  32'd1);
  endtask

  task automatic tx_write(input logic [7:0] d);
    for (int k = 0; k < 400 && !tx_ready; k++) @(negedge clk);
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_start(input logic [1:0] mode);
    cpol_cpha = mode;
    sck       = mode[1];
    repeat (8) @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master side of one byte (or its first nbits bits); mi holds miso as seen
  // at the master's sample edges.
  task automatic spi_xfer(input logic [1:0] mode, input logic [7:0] mo,
                          input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!mode[0]) begin
        mosi = mo[i];
        repeat (HALF) @(negedge clk);
        sck   = ~mode[1];
        mi[i] = miso;
        repeat (HALF) @(negedge clk);
        sck = mode[1];
      end else begin
        sck  = ~mode[1];
        mosi = mo[i];
        repeat (HALF) @(negedge clk);
        sck   = mode[1];
        mi[i] = miso;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] mi, mi0, mi1, d, expb;
  logic [1:0] mode;
  logic [7:0] tx_model[$];
  logic [7:0] mbs[$];
  int         n, pre, exp_und;

  initial begin
    reset_n   = 1'b0;
    cs_n      = 1'b1;
    sck       = 1'b0;
    mosi      = 1'b0;
    cpol_cpha = 2'b00;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    rx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, tx 0xA5 preloaded, master 0x3C, all four modes.
    for (int m = 0; m < 4; m++) begin
      rx_ready = 1'b0;
      snap();
      tx_write(8'hA5);
      cs_start(m[1:0]);
      spi_xfer(m[1:0], 8'h3C, 8, mi);
      cs_end();
      check($sformatf("m%0d_miso_byte", m), {24'd0, mi},       32'hA5);
      check($sformatf("m%0d_rx_data", m),   {24'd0, rx_data},  32'h3C);
      check($sformatf("m%0d_rx_valid", m),  {31'd0, rx_valid}, 32'd1);
      check($sformatf("m%0d_underrun", m),  und_cnt - base_u,  32'd0);
      check($sformatf("m%0d_overrun", m),   ovr_cnt - base_o,  32'd0);
      check($sformatf("m%0d_frame_err", m), ferr_cnt - base_f, 32'd0);
      check($sformatf("m%0d_busy_end", m),  {31'd0, busy},     32'd0);
      rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      check($sformatf("m%0d_rx_drained", m), {31'd0, rx_valid}, 32'd0);
    end

    // Two-byte frame, 0x22 written while byte 1 is in flight.
    snap();
    tx_write(8'h11);
    cs_start(2'b00);
    fork
      begin
        spi_xfer(2'b00, 8'hF0, 8, mi0);
        spi_xfer(2'b00, 8'h0F, 8, mi1);
      end
      begin
        repeat (40) @(negedge clk);
        tx_write(8'h22);
      end
    join
    cs_end();
    check("two_miso0",    {24'd0, mi0}, 32'h11);
    check("two_miso1",    {24'd0, mi1}, 32'h22);
    check("two_rx_count", rx_log.size() - base_rx, 32'd2);
    check("two_rx0",      {24'd0, rx_log[base_rx]},     32'hF0);
    check("two_rx1",      {24'd0, rx_log[base_rx + 1]}, 32'h0F);
    check("two_underrun", und_cnt - base_u, 32'd0);

    // No tx data: underrun once, zeros on miso.
    snap();
    cs_start(2'b00);
    spi_xfer(2'b00, 8'h55, 8, mi);
    cs_end();
    check("und_miso",     {24'd0, mi}, 32'h00);
    check("und_count",    und_cnt - base_u, 32'd1);
    check("und_rx_count", rx_log.size() - base_rx, 32'd1);
    check("und_rx",       {24'd0, rx_log[base_rx]}, 32'h55);

    // rx_ready low across two bytes: overrun once, last byte kept.
    rx_ready = 1'b0;
    snap();
    cs_start(2'b00);
    spi_xfer(2'b00, 8'h01, 8, mi);
    spi_xfer(2'b00, 8'h02, 8, mi);
    cs_end();
    check("ovr_count",    ovr_cnt - base_o, 32'd1);
    check("ovr_rx_data",  {24'd0, rx_data},  32'h02);
    check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Full byte 0x77 held unconsumed, then cs_n raised after 4 bits.
    rx_ready = 1'b0;
    snap();
    cs_start(2'b00);
    spi_xfer(2'b00, 8'h77, 8, mi);
    spi_xfer(2'b00, 8'h99, 4, mi);
    cs_end();
    check("ferr_count",    ferr_cnt - base_f, 32'd1);
    check("ferr_busy",     {31'd0, busy},     32'd0);
    check("ferr_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("ferr_rx_data",  {24'd0, rx_data},  32'h77);
    check("ferr_overrun",  ovr_cnt - base_o,  32'd0);

    // Reset mid-frame with rx_valid set and the tx buffer full.
    tx_write(8'hC3);
    cs_start(2'b01);
    spi_xfer(2'b01, 8'hFF, 3, mi);
    tx_write(8'h5A);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rx_ready = 1'b1;
    reset_n  = 1'b1;
    // cs_n is still low: no frame may start.
    repeat (30) @(negedge clk);
    check("cslow_busy",    {31'd0, busy},    32'd0);
    check("cslow_miso_oe", {31'd0, miso_oe}, 32'd0);
    sck  = 1'b0;
    cs_n = 1'b1;
    repeat (10) @(negedge clk);

    // Randomized frames against a byte-level model: each byte takes the
    // oldest queued tx byte, or 0x00 with one underrun.
    for (int it = 0; it < 6; it++) begin
      mode = 2'($urandom_range(0, 3));
      n    = $urandom_range(1, 3);
      pre  = $urandom_range(0, 1);
      snap();
      tx_model.delete();
      mbs.delete();
      exp_und = 0;
      if (pre != 0) begin
        d = 8'($urandom);
        tx_model.push_back(d);
        tx_write(d);
      end
      cs_start(mode);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        mbs.push_back(d);
        spi_xfer(mode, d, 8, mi);
        if (tx_model.size() > 0) begin
          expb = tx_model.pop_front();
        end else begin
          expb = 8'h00;
          exp_und++;
        end
        check($sformatf("rnd%0d_miso%0d", it, k), {24'd0, mi}, {24'd0, expb});
      end
      cs_end();
      check($sformatf("rnd%0d_rx_count", it), rx_log.size() - base_rx, n);
      for (int k = 0; k < n; k++) begin
        check($sformatf("rnd%0d_rx%0d", it, k), {24'd0, rx_log[base_rx + k]}, {24'd0, mbs[k]});
      end
      check($sformatf("rnd%0d_underrun", it),  und_cnt - base_u,  exp_und);
      check($sformatf("rnd%0d_overrun", it),   ovr_cnt - base_o,  32'd0);
      check($sformatf("rnd%0d_frame_err", it), ferr_cnt - base_f, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
